// File: rtl/frame_arb_pkg.sv
// frame_arb_pkg: shared types and default sizes for the frame-buffer arbiter
package frame_arb_pkg;

    typedef enum logic [1:0] {OWN_NONE, OWN_VGA, OWN_CMP} owner_t;
    typedef enum logic {ARB, LOCKED} arb_state_t;

    localparam int FB_ADDR_W = 17;
    localparam int FB_DATA_W = 8;
    localparam int FB_DEPTH  = 76800;

endpackage

// File: rtl/frame_arb_tag_pipe.sv
// frame_arb_tag_pipe: owner shift register tracking in-flight BRAM reads, flushed by reset
module frame_arb_tag_pipe
    import frame_arb_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic   clk_in,
    input  logic   rst_in,
    input  owner_t own_in,
    output owner_t next_out,
    output owner_t exit_out
);

    owner_t stage_q [DEPTH];

    // Shift owners one stage per cycle; reset drops every in-flight tag
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= OWN_NONE;
        end else begin
            stage_q[0] <= own_in;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    // next_out is the tag whose BRAM data is on the bus this cycle; exit_out drives the valids
    assign next_out = stage_q[DEPTH-2];
    assign exit_out = stage_q[DEPTH-1];

endmodule

// File: rtl/frame_buffer_arbiter.sv
// frame_buffer_arbiter: single-port BRAM arbiter for VGA reads and compare RMW; FRAME_ARB_STATS_EN enables the VGA stall counter
module frame_buffer_arbiter
    import frame_arb_pkg::*;
#(
    parameter int ADDR_W     = FB_ADDR_W,
    parameter int DATA_W     = FB_DATA_W,
    parameter int BRAM_LAT   = 2,
    parameter int STARVE_MAX = 8,
    parameter int LOCK_MAX   = 6
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              vga_req_in,
    input  logic [ADDR_W-1:0] vga_addr_in,
    output logic              vga_gnt_out,
    output logic [DATA_W-1:0] vga_data_out,
    output logic              vga_valid_out,
    input  logic              cmp_req_in,
    input  logic              cmp_we_in,
    input  logic [ADDR_W-1:0] cmp_addr_in,
    input  logic [DATA_W-1:0] cmp_data_in,
    input  logic              cmp_lock_in,
    output logic              cmp_gnt_out,
    output logic [DATA_W-1:0] cmp_data_out,
    output logic              cmp_valid_out,
    output logic [ADDR_W-1:0] bram_addr_out,
    output logic              bram_we_out,
    output logic [DATA_W-1:0] bram_din_out,
    input  logic [DATA_W-1:0] bram_dout_in,
    output logic              lock_timeout_out,
    output logic [15:0]       vga_stall_cnt_out
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int LW = $clog2(LOCK_MAX + 1);

    arb_state_t        state_q, state_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [LW-1:0]     lock_q, lock_d;
    logic              timeout_q, timeout_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [DATA_W-1:0] vga_data_q, cmp_data_q;
    owner_t            own_d, tag_next, tag_exit;

    // Grant, starvation, lock FSM and issue selection
    always_comb begin
        vga_gnt_out = state_q == ARB && vga_req_in && starve_q < SW'(STARVE_MAX);
        cmp_gnt_out = cmp_req_in && !vga_gnt_out;
        starve_d    = (cmp_gnt_out || !cmp_req_in) ? '0
                    : (starve_q == SW'(STARVE_MAX)) ? starve_q : starve_q + 1'b1;
        state_d     = state_q;
        lock_d      = lock_q;
        timeout_d   = timeout_q;
        if (state_q == ARB) begin
            if (cmp_gnt_out && !cmp_we_in && cmp_lock_in) begin
                state_d = LOCKED;
                lock_d  = '0;
            end
        end else begin
            lock_d = lock_q + 1'b1;
            if (cmp_gnt_out && cmp_we_in) begin
                state_d = ARB;
            end else if (lock_d == LW'(LOCK_MAX)) begin
                state_d   = ARB;
                timeout_d = 1'b1;
            end else if (!cmp_lock_in) begin
                state_d = ARB;
            end
        end
        addr_d = vga_gnt_out ? vga_addr_in : cmp_gnt_out ? cmp_addr_in : addr_q;
        we_d   = cmp_gnt_out && cmp_we_in;
        din_d  = we_d ? cmp_data_in : din_q;
        own_d  = vga_gnt_out ? OWN_VGA : (cmp_gnt_out && !cmp_we_in) ? OWN_CMP : OWN_NONE;
    end

    // Arbitration state and registered BRAM port
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= ARB;
            starve_q  <= '0;
            lock_q    <= '0;
            timeout_q <= 1'b0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            din_q     <= '0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            lock_q    <= lock_d;
            timeout_q <= timeout_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            din_q     <= din_d;
        end
    end

    frame_arb_tag_pipe #(.DEPTH(BRAM_LAT + 1)) u_tag_pipe (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .own_in  (own_d),
        .next_out(tag_next),
        .exit_out(tag_exit)
    );

    // Capture read data for whichever requester owns the returning access
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            vga_data_q <= '0;
            cmp_data_q <= '0;
        end else begin
            vga_data_q <= (tag_next == OWN_VGA) ? bram_dout_in : vga_data_q;
            cmp_data_q <= (tag_next == OWN_CMP) ? bram_dout_in : cmp_data_q;
        end
    end

`ifdef FRAME_ARB_STATS_EN
    logic [15:0] stall_q;

    // Saturating count of cycles VGA asked but was refused
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) stall_q <= '0;
        else if (vga_req_in && !vga_gnt_out && stall_q != 16'hFFFF) stall_q <= stall_q + 1'b1;
    end

    assign vga_stall_cnt_out = stall_q;
`else
    assign vga_stall_cnt_out = '0;
`endif

    assign vga_valid_out    = tag_exit == OWN_VGA;
    assign cmp_valid_out    = tag_exit == OWN_CMP;
    assign vga_data_out     = vga_data_q;
    assign cmp_data_out     = cmp_data_q;
    assign bram_addr_out    = addr_q;
    assign bram_we_out      = we_q;
    assign bram_din_out     = din_q;
    assign lock_timeout_out = timeout_q;

endmodule

// File: doc/frame_buffer_arbiter.md
# frame_buffer_arbiter

Shares one 65 MHz port of the 320x240x8 frame-buffer BRAM between the VGA readout path (mirror address generator) and the compare read-modify-write path. This removes the duplicated VGA BRAM, so one buffer feeds the display, compare, and the Ethernet port-B reader. The block issues at most one BRAM access per cycle. It tags each read so its data returns only to the requester that issued it. It also keeps a compare read-modify-write atomic against VGA traffic.

## Interface
- ADDR_W, 17, BRAM address width (320*240 words)
- DATA_W, 8, pixel width
- BRAM_LAT, 2, BRAM read latency in cycles from a registered address
- STARVE_MAX, 8, maximum consecutive cycles compare may be denied by VGA
- LOCK_MAX, 6, maximum cycles compare may hold the lock
- clk_in  input  1  65 MHz system clock
- rst_in  input  1  asynchronous, active-high reset
- vga_req_in  input  1  VGA read request
- vga_addr_in  input  ADDR_W  VGA read address
- vga_gnt_out  output  1  VGA request accepted this cycle (combinational)
- vga_data_out  output  DATA_W  VGA read data
- vga_valid_out  output  1  vga_data_out valid
- cmp_req_in  input  1  compare request
- cmp_we_in  input  1  compare request is a write
- cmp_addr_in  input  ADDR_W  compare address
- cmp_data_in  input  DATA_W  compare write data
- cmp_lock_in  input  1  hold the port for a read-modify-write
- cmp_gnt_out  output  1  compare request accepted this cycle (combinational)
- cmp_data_out  output  DATA_W  compare read data
- cmp_valid_out  output  1  cmp_data_out valid
- bram_addr_out  output  ADDR_W  registered BRAM address
- bram_we_out  output  1  registered BRAM write enable
- bram_din_out  output  DATA_W  registered BRAM write data
- bram_dout_in  input  DATA_W  BRAM read data
- lock_timeout_out  output  1  sticky flag: a lock was force-released
- vga_stall_cnt_out  output  16  saturating count of denied VGA requests

## Operation
- States are ARB and LOCKED.
- **ARB:**
  - Arbitration counter: starve_cnt counts consecutive cycles in which cmp_req_in is high but not granted.
  - If vga_req_in is high and starve_cnt < STARVE_MAX, VGA is granted.
  - Otherwise, if cmp_req_in is high, compare is granted.
  - A compare grant clears starve_cnt.
  - A granted compare read with cmp_lock_in high moves the FSM to LOCKED.
- **LOCKED:**
  - Only compare can be granted; VGA is denied.
  - Exit to ARB on either:
    - a granted compare write, or
    - lock_cnt reaching LOCK_MAX, which also sets lock_timeout_out.
  - cmp_lock_in falling also exits to ARB on the next cycle.
- **Issue:**
  - The granted request is registered onto the bram_* outputs.
  - With no grant, bram_we_out = 0 and bram_addr_out holds its value.
- **Tags:**
  - A BRAM_LAT+1 deep shift register carries the owner of each issued access: NONE, VGA or CMP.
  - Writes carry NONE.
  - When the tag exits the register, the owner's valid output pulses and its data output is loaded from bram_dout_in.
- The BRAM is read-first. A VGA read of an address written by compare in the same cycle returns the old value; this is required behaviour.
- vga_stall_cnt_out increments whenever vga_req_in is high and vga_gnt_out is low. It saturates at 0xFFFF.

## Timing
- Latency from grant cycle to owner valid is 1 + BRAM_LAT cycles (3 at the default).
- The block accepts one access per cycle. vga_valid_out and cmp_valid_out are never high together.
- Reset values of all outputs:
  - valid outputs, bram_we_out, lock_timeout_out, counters: 0
  - state: ARB
  - tag register: all NONE
  - data outputs and bram_addr_out: 0
- Reset asserted mid-operation flushes the tag register; no valid pulse follows for any access issued before reset.
- A request is not held internally. A denied requester must keep its request asserted.

## Configuration
- `FRAME_ARB_STATS_EN` defined: vga_stall_cnt_out counts as specified above.
- `FRAME_ARB_STATS_EN` undefined: vga_stall_cnt_out is tied to 0 and its counter is not synthesised. All other behaviour is identical.

## Structure
- Package frame_arb_pkg holds:
  - owner_t enum {OWN_NONE, OWN_VGA, OWN_CMP}
  - arb_state_t enum {ARB, LOCKED}
  - default constants FB_ADDR_W = 17, FB_DATA_W = 8, FB_DEPTH = 76800
- Sub-module frame_arb_tag_pipe implements the parameterised owner/valid shift register with asynchronous flush.

## Test plan
- VGA-only reads: vga_req_in high with addr 0..9 each cycle -> vga_valid_out high 3 cycles after each grant, with data equal to the BRAM contents at that address in order; cmp_valid_out stays 0.
- Starvation: vga_req_in and cmp_req_in held high continuously -> compare is granted on the 9th cycle (starve_cnt = 8), then VGA resumes; vga_stall_cnt_out = 1.
- Read-modify-write: compare locked read of addr 0x100, VGA requesting throughout, compare write of 0x3F to 0x100 two cycles later -> VGA is denied for those cycles, and a following VGA read of 0x100 returns 0x3F.
- Lock timeout: compare holds cmp_lock_in for 10 cycles without writing -> FSM returns to ARB after 6 locked cycles, lock_timeout_out = 1 and stays 1.
- Same-cycle conflict: compare write of 0xAA to addr 5 issued, then a VGA read of addr 5 issued in the next cycle -> the read-first rule applies as specified, and the write is never lost.
- Reset during traffic: rst_in pulsed one cycle after a VGA grant -> no vga_valid_out pulse follows; all outputs read 0.
